cache_traffic_gen: RTL
======================

CACHE_TRAFFIC_GEN -- requirements
Module: cache_traffic_gen

Interface
REQ-001 SHALL have parameter ADDR_LENTH, default 32, meaning address width in bits.
REQ-002 SHALL have parameter LINE_SIZE, default 128, meaning cache line width in bits; it is a multiple of 32.
REQ-003 SHALL have parameter N_RD, default 2, meaning number of read channels (1..8).
REQ-004 SHALL have parameter DIV, default 4, meaning issue-tick period in clk cycles (>=2).
REQ-005 SHALL have parameter N_OPS, default 16, meaning lines written and read per run (1..65535).
REQ-006 SHALL have parameter MAX_RETRY, default 3, meaning reissues allowed per op after a miss.
REQ-007 SHALL have parameter BASE_ADDR, default 0, meaning first line address.
REQ-008 SHALL have parameter SEED, default 32'hA5A5_0000, meaning data pattern key.
REQ-009 SHALL have ports clk (input, 1, the single clock) and rst (input, 1, synchronous active-low reset).
REQ-010 SHALL have port start (input, 1, begins a run).
REQ-011 SHALL have ports re_i (output, N_RD, per-channel read request) and raddr_i (output, N_RD*ADDR_LENTH, channel c in bits [c*ADDR_LENTH +: ADDR_LENTH]).
REQ-012 SHALL have ports rdata_o (input, N_RD*LINE_SIZE, per-channel read data) and read_hit_o (input, N_RD, per-channel hit).
REQ-013 SHALL have ports we_i (output, 1, write request), waddr_i (output, ADDR_LENTH, write address), wdata_i (output, LINE_SIZE, write data) and write_hit_o (input, 1, write hit).
REQ-014 SHALL have ports tick (output, 1, issue strobe), busy (output, 1, run active), done (output, 1, run complete), miss_cnt (output, 16, exhausted ops) and err_cnt (output, 16, data mismatches).

Function
REQ-015 SHALL run a free-running tick counter 0..DIV-1 from reset and assert tick for one cycle when the counter equals DIV-1.
REQ-016 SHALL compute the line address for index k as BASE_ADDR + k*(LINE_SIZE/8), modulo 2^ADDR_LENTH.
REQ-017 SHALL compute pattern(a) as the 32-bit word (a ^ SEED) + word index, replicated across LINE_SIZE/32 words, with word 0 in the LSBs.
REQ-018 SHALL implement the states IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT and DONE.
REQ-019 IDLE, or DONE, with start=1 SHALL go to WR_ISSUE with k=0 and both counters cleared; start SHALL be ignored in every other state.
REQ-020 WR_ISSUE SHALL wait for tick; on the tick cycle it SHALL assert we_i with address(k) and pattern(address(k)) for exactly one cycle, then go to WR_WAIT.
REQ-021 WR_WAIT SHALL sample write_hit_o in the cycle after issue.
- Hit: advance k.
- Miss with retries < MAX_RETRY: return to WR_ISSUE with the same k.
- Miss with retries exhausted: increment miss_cnt, then advance.
REQ-022 After the write for k=N_OPS-1 completes, the block SHALL go to RD_ISSUE with k=0.
REQ-023 RD_ISSUE SHALL, on tick, pulse re_i for one cycle on every still-pending channel; channel c SHALL read address((k+c) mod N_OPS).
REQ-024 RD_WAIT SHALL sample each pending channel's read_hit_o in the cycle after issue.
- Hit: clear that channel's pending bit; if rdata_o differs from the expected pattern, increment err_cnt once for that channel.
REQ-025 A read op SHALL complete when no channel is pending or after MAX_RETRY reissues; each channel still pending at that point SHALL add 1 to miss_cnt, with all such channels counted in the same cycle.
REQ-026 After read op k=N_OPS-1 completes, the block SHALL go to DONE; DONE SHALL hold done=1 and busy=0 until start is asserted.
REQ-027 busy SHALL be 1 in the states WR_ISSUE through RD_WAIT; we_i, re_i, raddr_i, waddr_i and wdata_i SHALL be 0 whenever no request is asserted.
REQ-028 miss_cnt and err_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-029 While rst=0 at a clk edge, the block SHALL force state IDLE, tick counter 0, and k, retry count and pending bits to 0.
REQ-030 While rst=0 at a clk edge, the block SHALL drive all outputs to 0, including the counters.
REQ-031 Reset asserted mid-run SHALL abort the run with no further requests issued, and the first tick SHALL occur DIV cycles after rst returns to 1.

Verification
REQ-032 The bench SHALL cover: N_OPS=4, DIV=4, all hits -> 4 writes spaced 4 cycles, 4 read ops, done=1, miss_cnt=0, err_cnt=0, addresses 0,16,32,48.
REQ-033 The bench SHALL cover: write_hit_o=0 forever on k=2 with MAX_RETRY=3 -> 4 we_i pulses at address 32, then miss_cnt=1 and the write to 48 proceeds.
REQ-034 The bench SHALL cover: N_RD=2, channel 1 returns data with bit 0 flipped on its first read -> err_cnt=1, and channel 0 reads are unaffected.
REQ-035 The bench SHALL cover: channel 0 hits and channel 1 misses 4 times -> only re_i[1] reissues, and miss_cnt increments by exactly 1.
REQ-036 The bench SHALL cover: rst=0 during RD_WAIT -> the next cycle shows busy=0, re_i=0 and counters 0; start then yields a full clean run.
REQ-037 The bench SHALL cover: start pulsed while busy -> no effect; start in DONE -> counters cleared and a new run begins.

Source files
------------

// File: rtl/cache_traffic_gen.sv
// cache_traffic_gen
// Writes N_OPS cache lines with a seeded data pattern, then reads every line
// back over N_RD parallel read channels and checks the returned data.
// Requests are issued only on the periodic tick; misses are retried up to
// MAX_RETRY times before an op is counted as missed.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   start               begins a run (accepted only in IDLE or DONE)
//   re_i, raddr_i       per-channel read request and address (outputs)
//   rdata_o, read_hit_o per-channel read data and hit (inputs)
//   we_i, waddr_i,      write request, address and data (outputs)
//   wdata_i
//   write_hit_o         write hit (input)
//   tick                one-cycle issue strobe every DIV cycles
//   busy, done          run active / run complete
//   miss_cnt, err_cnt   saturating counts of exhausted ops / data mismatches
//
// state      | meaning
// S_IDLE     | after reset, waiting for start
// S_WR_ISSUE | waiting for tick, then pulse the write for line k
// S_WR_WAIT  | sample write_hit_o, retry or advance k
// S_RD_ISSUE | waiting for tick, then pulse reads on pending channels
// S_RD_WAIT  | sample read hits/data, retry or advance k
// S_DONE     | run finished, done held until start
module cache_traffic_gen #(
  parameter int          ADDR_LENTH = 32,
  parameter int          LINE_SIZE  = 128,
  parameter int          N_RD       = 2,
  parameter int          DIV        = 4,
  parameter int          N_OPS      = 16,
  parameter int          MAX_RETRY  = 3,
  parameter logic [63:0] BASE_ADDR  = 64'd0,
  parameter logic [31:0] SEED       = 32'hA5A5_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [N_RD-1:0]              re_i,
  output logic [N_RD*ADDR_LENTH-1:0]   raddr_i,
  input  logic [N_RD*LINE_SIZE-1:0]    rdata_o,
  input  logic [N_RD-1:0]              read_hit_o,
  output logic                         we_i,
  output logic [ADDR_LENTH-1:0]        waddr_i,
  output logic [LINE_SIZE-1:0]         wdata_i,
  input  logic                         write_hit_o,
  output logic                         tick,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  miss_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [ADDR_LENTH-1:0] STRIDE = ADDR_LENTH'(LINE_SIZE / 8);
  localparam logic [15:0] MAX_R  = 16'(MAX_RETRY);
  localparam logic [15:0] LAST_K = 16'(N_OPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     k_q, k_d;
  logic [15:0]     retry_q, retry_d;
  logic [N_RD-1:0] pend_q, pend_d;
  logic [15:0]     miss_q, miss_d;
  logic [15:0]     err_q, err_d;
  logic [3:0]      miss_inc, err_inc;
  logic [N_RD-1:0] remain;
  logic            clr_cnt;

  function automatic logic [ADDR_LENTH-1:0] line_addr(input logic [15:0] k);
    return ADDR_LENTH'(BASE_ADDR) + ADDR_LENTH'(k) * STRIDE;
  endfunction

  // Channel c reads line (k+c) mod N_OPS so channels spread over the lines.
  function automatic logic [15:0] rd_index(input logic [15:0] k, input int c);
    return 16'((int'(k) + c) % N_OPS);
  endfunction

  function automatic logic [LINE_SIZE-1:0] pattern(input logic [ADDR_LENTH-1:0] a);
    logic [LINE_SIZE-1:0] p;
    p = '0;
    for (int w = 0; w < LINE_SIZE / 32; w++) begin
      p[w*32 +: 32] = (32'(a) ^ SEED) + 32'(w);
    end
    return p;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    retry_d  = retry_q;
    pend_d   = pend_q;
    miss_inc = '0;
    err_inc  = '0;
    clr_cnt  = 1'b0;
    remain   = pend_q;
    we_i     = 1'b0;
    waddr_i  = '0;
    wdata_i  = '0;
    re_i     = '0;
    raddr_i  = '0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          state_d = S_WR_ISSUE;
          k_d     = '0;
          retry_d = '0;
          pend_d  = '0;
          clr_cnt = 1'b1;
        end
      end
      S_WR_ISSUE: begin
        busy = 1'b1;
        if (tick) begin
          we_i    = 1'b1;
          waddr_i = line_addr(k_q);
          wdata_i = pattern(line_addr(k_q));
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        busy = 1'b1;
        if (write_hit_o || retry_q >= MAX_R) begin
          if (!write_hit_o) miss_inc = 4'd1;
          retry_d = '0;
          if (k_q == LAST_K) begin
            state_d = S_RD_ISSUE;
            k_d     = '0;
            pend_d  = '1;
          end else begin
            state_d = S_WR_ISSUE;
            k_d     = k_q + 16'd1;
          end
        end else begin
          retry_d = retry_q + 16'd1;
          state_d = S_WR_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        busy = 1'b1;
        if (tick) begin
          re_i = pend_q;
          for (int c = 0; c < N_RD; c++) begin
            if (pend_q[c]) raddr_i[c*ADDR_LENTH +: ADDR_LENTH] = line_addr(rd_index(k_q, c));
          end
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        busy = 1'b1;
        for (int c = 0; c < N_RD; c++) begin
          if (pend_q[c] && read_hit_o[c]) begin
            remain[c] = 1'b0;
            if (rdata_o[c*LINE_SIZE +: LINE_SIZE] != pattern(line_addr(rd_index(k_q, c))))
              err_inc = err_inc + 4'd1;
          end
        end
        if (remain == '0 || retry_q >= MAX_R) begin
          // Every channel still pending at completion counts as one miss.
          for (int c = 0; c < N_RD; c++) begin
            if (remain[c]) miss_inc = miss_inc + 4'd1;
          end
          retry_d = '0;
          if (k_q == LAST_K) begin
            state_d = S_DONE;
            k_d     = '0;
            pend_d  = '0;
          end else begin
            state_d = S_RD_ISSUE;
            k_d     = k_q + 16'd1;
            pend_d  = '1;
          end
        end else begin
          retry_d = retry_q + 16'd1;
          pend_d  = remain;
          state_d = S_RD_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    miss_d = clr_cnt ? 16'd0 : sat_add(miss_q, miss_inc);
    err_d  = clr_cnt ? 16'd0 : sat_add(err_q, err_inc);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      retry_q <= '0;
      pend_q  <= '0;
      miss_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  assign miss_cnt = miss_q;
  assign err_cnt  = err_q;

endmodule
